// File: rtl/wb_burst_dma_pkg.sv
// Shared definitions for the Wishbone burst DMA: FSM states, register map
// offsets, CTRL bit positions and a byte-lane merge helper.
package wb_burst_dma_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARB    = 2'd1,
    BURST  = 2'd2,
    UPDATE = 2'd3
  } dma_state_t;

  localparam logic [3:0] OFF_SRC  = 4'h0;
  localparam logic [3:0] OFF_LEN  = 4'h4;
  localparam logic [3:0] OFF_CTRL = 4'h8;

  localparam int CTRL_START = 0;
  localparam int CTRL_BUSY  = 1;
  localparam int CTRL_DONE  = 2;
  localparam int CTRL_IE    = 3;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  sel);
    logic [31:0] r;
    for (int b = 0; b < 4; b++)
      r[b*8 +: 8] = sel[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
    return r;
  endfunction

endpackage

// File: rtl/burst_fifo.sv
// First-word-fall-through FIFO holding DRAM beats on their way to the
// accelerator; the head entry is visible on dout whenever empty is low.
module burst_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign do_push = push && (count != FULL_CNT);
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is pure data and is never reset; occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/wb_burst_dma.sv
// Multi-channel read DMA: Wishbone slave register file, round-robin burst
// reader on a Wishbone DRAM master, and a tagged stream to the accelerator.
module wb_burst_dma
  import wb_burst_dma_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter int          DEPTH      = 4,
  parameter int          NUM_CH     = 2,
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  localparam int         CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_we_i,
  input  logic [3:0]            wbs_sel_i,
  input  logic [31:0]           wbs_adr_i,
  input  logic [31:0]           wbs_dat_i,
  output logic                  wbs_ack_o,
  output logic [31:0]           wbs_dat_o,
  output logic                  dram_cyc_o,
  output logic                  dram_stb_o,
  output logic                  dram_we_o,
  output logic                  dram_burst_o,
  output logic [31:0]           dram_adr_o,
  input  logic                  dram_ack_i,
  input  logic [DATA_WIDTH-1:0] dram_dat_i,
  output logic                  acc_valid_o,
  input  logic                  acc_ready_i,
  output logic [DATA_WIDTH-1:0] acc_data_o,
  output logic [CH_W-1:0]       acc_ch_o,
  output logic                  acc_last_o,
  output logic                  irq_o
);
  localparam int BW = $clog2(DEPTH) + 1;
  localparam int FW = DATA_WIDTH + CH_W + 1;
  localparam logic [BW-1:0]   DEPTH_B  = BW'(DEPTH);
  localparam logic [15:0]     DEPTH_16 = 16'(DEPTH);
  localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NUM_CH - 1);
  localparam logic [2:0]      NUM_CH_L = 3'(NUM_CH);

  logic [31:0]       src [NUM_CH];
  logic [15:0]       len [NUM_CH];
  logic [NUM_CH-1:0] busy;
  logic [NUM_CH-1:0] done;
  logic [NUM_CH-1:0] ie;

  logic              ack_q;
  logic [31:0]       dat_q;
  logic              irq_q;

  dma_state_t        state;
  dma_state_t        state_next;
  logic [CH_W-1:0]   cur_ch;
  logic [CH_W-1:0]   rr_ptr;
  logic [BW-1:0]     beats_left;
  logic [BW-1:0]     beats_total;
  logic              final_burst;
  logic [31:0]       adr_q;

  logic              wb_hit;
  logic              wb_req;
  logic [1:0]        reg_ch;
  logic [CH_W-1:0]   ch_idx;
  logic [3:0]        reg_off;
  logic              ch_ok;
  logic [31:0]       rd_val;
  logic [31:0]       wr_merged;

  logic              sel_found;
  logic [CH_W-1:0]   sel_ch;
  logic [CH_W-1:0]   cand;
  logic [BW-1:0]     arb_beats;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_empty;
  logic [FW-1:0]     fifo_din;
  logic [FW-1:0]     fifo_dout;
  logic [BW-1:0]     fifo_count;
  logic              unused_ok;

  assign unused_ok = ^wbs_adr_i[1:0];

  // Slave decode: ack_q blocks a second ack while the master still holds stb.
  assign wb_hit    = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign wb_req    = wb_hit & ~ack_q;
  assign reg_ch    = wbs_adr_i[5:4];
  assign ch_idx    = CH_W'(reg_ch);
  assign reg_off   = {wbs_adr_i[3:2], 2'b00};
  assign ch_ok     = (wbs_adr_i[7:6] == 2'b00) && ({1'b0, reg_ch} < NUM_CH_L);
  assign wr_merged = byte_merge(rd_val, wbs_dat_i, wbs_sel_i);

  always_comb begin
    rd_val = '0;
    if (ch_ok) begin
      case (reg_off)
        OFF_SRC:  rd_val = src[ch_idx];
        OFF_LEN:  rd_val = {16'b0, len[ch_idx]};
        OFF_CTRL: begin
          rd_val[CTRL_BUSY] = busy[ch_idx];
          rd_val[CTRL_DONE] = done[ch_idx];
          rd_val[CTRL_IE]   = ie[ch_idx];
        end
        default:  rd_val = '0;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q <= 1'b0;
      dat_q <= '0;
      irq_q <= 1'b0;
      busy  <= '0;
      done  <= '0;
      ie    <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        src[c] <= '0;
        len[c] <= '0;
      end
    end else begin
      ack_q <= wb_req;
      if (wb_req) dat_q <= rd_val;
      if (wb_req && wbs_we_i && ch_ok) begin
        case (reg_off)
          OFF_SRC:  if (!busy[ch_idx]) src[ch_idx] <= wr_merged & 32'hFFFF_FFFC;
          OFF_LEN:  if (!busy[ch_idx]) len[ch_idx] <= wr_merged[15:0];
          OFF_CTRL: if (wbs_sel_i[0]) begin
            ie[ch_idx] <= wbs_dat_i[CTRL_IE];
            if (wbs_dat_i[CTRL_DONE]) done[ch_idx] <= 1'b0;
            if (wbs_dat_i[CTRL_START] && !busy[ch_idx]) begin
              if (len[ch_idx] == 16'd0) done[ch_idx] <= 1'b1;
              else                      busy[ch_idx] <= 1'b1;
            end
          end
          default: ;
        endcase
      end
      // Burst bookkeeping lands after slave writes so a completion beats a DONE clear.
      if (state == UPDATE) begin
        src[cur_ch] <= src[cur_ch] + {{(30-BW){1'b0}}, beats_total, 2'b00};
        len[cur_ch] <= len[cur_ch] - 16'(beats_total);
        if (len[cur_ch] == 16'(beats_total)) begin
          busy[cur_ch] <= 1'b0;
          done[cur_ch] <= 1'b1;
        end
      end
      irq_q <= |(done & ie);
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign irq_o     = irq_q;

  // Round-robin pick: first busy channel at or after rr_ptr.
  always_comb begin
    sel_found = 1'b0;
    sel_ch    = '0;
    cand      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = CH_W'((int'(rr_ptr) + i) % NUM_CH);
      if (!sel_found && busy[cand]) begin
        sel_found = 1'b1;
        sel_ch    = cand;
      end
    end
  end

  assign arb_beats = (len[sel_ch] >= DEPTH_16) ? DEPTH_B : BW'(len[sel_ch]);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next   = state;
    dram_cyc_o   = 1'b0;
    dram_stb_o   = 1'b0;
    dram_burst_o = 1'b0;
    case (state)
      IDLE:   if (|busy && fifo_count == '0) state_next = ARB;
      ARB:    state_next = sel_found ? BURST : IDLE;
      BURST: begin
        dram_cyc_o   = 1'b1;
        dram_stb_o   = 1'b1;
        dram_burst_o = 1'b1;
        if (dram_ack_i && beats_left == BW'(1)) state_next = UPDATE;
      end
      UPDATE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cur_ch      <= '0;
      rr_ptr      <= '0;
      beats_left  <= '0;
      beats_total <= '0;
      final_burst <= 1'b0;
      adr_q       <= '0;
    end else begin
      case (state)
        ARB: begin
          cur_ch      <= sel_ch;
          rr_ptr      <= (sel_ch == LAST_CH) ? '0 : sel_ch + 1'b1;
          adr_q       <= src[sel_ch];
          beats_total <= arb_beats;
          beats_left  <= arb_beats;
          final_burst <= (len[sel_ch] <= DEPTH_16);
        end
        BURST: if (dram_ack_i) begin
          adr_q      <= adr_q + 32'd4;
          beats_left <= beats_left - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign dram_we_o  = 1'b0;
  assign dram_adr_o = adr_q;

  assign fifo_push = (state == BURST) && dram_ack_i;
  assign fifo_din  = {dram_dat_i, cur_ch, final_burst && (beats_left == BW'(1))};
  assign fifo_pop  = acc_valid_o & acc_ready_i;

  burst_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  assign acc_valid_o = ~fifo_empty;
  assign acc_data_o  = fifo_empty ? '0 : fifo_dout[FW-1 -: DATA_WIDTH];
  assign acc_ch_o    = fifo_empty ? '0 : fifo_dout[CH_W:1];
  assign acc_last_o  = ~fifo_empty & fifo_dout[0];

endmodule

// File: tb/tb_wb_burst_dma.sv
// Directed bench for wb_burst_dma: register access, burst ordering, FIFO
// back-pressure, zero-length start, busy write protection and mid-burst reset.
module tb_wb_burst_dma;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        dram_cyc_o, dram_stb_o, dram_we_o, dram_burst_o;
  logic [31:0] dram_adr_o;
  logic        dram_ack_i;
  logic [31:0] dram_dat_i;
  logic        acc_valid_o, acc_ready_i;
  logic [31:0] acc_data_o;
  logic [0:0]  acc_ch_o;
  logic        acc_last_o, irq_o;

  int checks = 0;
  int errors = 0;

  logic [63:0] words [$];
  logic [31:0] bursts [$];
  int          acks_total = 0;
  logic        cyc_d = 1'b0;
  int          wbase, bbase, abase;

  wb_burst_dma dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .dram_cyc_o(dram_cyc_o), .dram_stb_o(dram_stb_o), .dram_we_o(dram_we_o),
    .dram_burst_o(dram_burst_o), .dram_adr_o(dram_adr_o),
    .dram_ack_i(dram_ack_i), .dram_dat_i(dram_dat_i),
    .acc_valid_o(acc_valid_o), .acc_ready_i(acc_ready_i),
    .acc_data_o(acc_data_o), .acc_ch_o(acc_ch_o),
    .acc_last_o(acc_last_o), .irq_o(irq_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Zero-wait DRAM: every strobed cycle is acked; data encodes the address.
  assign dram_ack_i = dram_cyc_o & dram_stb_o;
  assign dram_dat_i = dram_adr_o + 32'h1000_0000;

  always @(negedge wb_clk_i) begin
    if (acc_valid_o && acc_ready_i)
      words.push_back({acc_data_o, 16'(acc_ch_o), 15'b0, acc_last_o});
    if (dram_cyc_o && !cyc_d) bursts.push_back(dram_adr_o);
    if (dram_cyc_o && dram_ack_i) acks_total <= acks_total + 1;
    cyc_d <= dram_cyc_o;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ra(input int ch, input int off);
    return BASE + 32'(ch * 16 + off);
  endfunction

  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                         output logic [31:0] rdat, output int acks);
    acks = 0;
    rdat = '0;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_sel_i = 4'hF; wbs_adr_i = adr; wbs_dat_i = wdat;
    for (int i = 0; i < 8 && acks == 0; i++) begin
      @(negedge wb_clk_i);
      if (wbs_ack_o) begin
        acks++;
        rdat = wbs_dat_o;
      end
      @(posedge wb_clk_i); #1;
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    @(negedge wb_clk_i);
    if (wbs_ack_o) acks++;
    @(posedge wb_clk_i); #1;
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat);
    logic [31:0] rd;
    int          acks;
    wb_xfer(1'b1, adr, dat, rd, acks);
    chk($sformatf("wr_ack_%0h", adr), 64'(acks), 64'd1);
  endtask

  task automatic wb_read(input logic [31:0] adr, input logic [31:0] exp, input string tag);
    logic [31:0] rd;
    int          acks;
    wb_xfer(1'b0, adr, 32'h0, rd, acks);
    chk({tag, "_ack"}, 64'(acks), 64'd1);
    chk(tag, 64'(rd), 64'(exp));
  endtask

  task automatic do_reset();
    wb_rst_i = 1'b1;
    repeat (2) @(posedge wb_clk_i);
    #1 wb_rst_i = 1'b0;
  endtask

  task automatic mark();
    wbase = words.size();
    bbase = bursts.size();
    abase = acks_total;
  endtask

  task automatic wait_words(input int n);
    for (int i = 0; i < 600 && (words.size() - wbase) < n; i++) @(posedge wb_clk_i);
    #1;
    chk("word_count", 64'(words.size() - wbase), 64'(n));
    repeat (4) @(posedge wb_clk_i);
    #1;
  endtask

  task automatic exp_seg(input int at, input logic [31:0] a0, input int n,
                         input int ch, input logic last_end);
    for (int k = 0; k < n; k++) begin
      logic [31:0] a;
      a = a0 + 32'(4 * k);
      chk($sformatf("word%0d", at + k), words[wbase + at + k],
          {a + 32'h1000_0000, 16'(ch), 15'b0, (last_end && k == n - 1)});
    end
  endtask

  initial begin
    logic [31:0] rd;
    int          acks;

    wb_rst_i = 1'b1;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    wbs_sel_i = 4'h0; wbs_adr_i = '0; wbs_dat_i = '0;
    acc_ready_i = 1'b0;
    repeat (3) @(posedge wb_clk_i);
    #1 wb_rst_i = 1'b0;

    // Reset state
    chk("rst_ack", 64'(wbs_ack_o), 64'd0);
    chk("rst_wbdat", 64'(wbs_dat_o), 64'd0);
    chk("rst_cyc", 64'(dram_cyc_o), 64'd0);
    chk("rst_valid", 64'(acc_valid_o), 64'd0);
    chk("rst_irq", 64'(irq_o), 64'd0);
    wb_read(ra(0, 0), 32'h0, "rst_src0");
    wb_read(ra(0, 4), 32'h0, "rst_len0");
    wb_read(ra(1, 8), 32'h0, "rst_ctrl1");
    wb_xfer(1'b0, 32'h3000_0100, 32'h0, rd, acks);
    chk("out_of_window_ack", 64'(acks), 64'd0);

    // Single channel, 8 words in two 4-beat bursts
    acc_ready_i = 1'b1;
    mark();
    wb_write(ra(0, 0), 32'h0000_0103);
    wb_read(ra(0, 0), 32'h0000_0100, "src_lsb_forced");
    wb_write(ra(0, 4), 32'd8);
    wb_write(ra(0, 8), 32'h1);
    wait_words(8);
    chk("t1_bursts", 64'(bursts.size() - bbase), 64'd2);
    chk("t1_b0_adr", 64'(bursts[bbase]), 64'h100);
    chk("t1_b1_adr", 64'(bursts[bbase + 1]), 64'h110);
    chk("t1_acks", 64'(acks_total - abase), 64'd8);
    exp_seg(0, 32'h100, 8, 0, 1'b1);
    wb_read(ra(0, 8), 32'h4, "t1_ctrl_done");
    wb_read(ra(0, 0), 32'h120, "t1_src_final");
    wb_read(ra(0, 4), 32'h0, "t1_len_final");
    wb_read(ra(0, 'hC), 32'h0, "unmapped_off");
    wb_write(ra(3, 0), 32'h5555_5554);
    wb_read(ra(3, 0), 32'h0, "unmapped_ch");
    wb_write(ra(0, 8), 32'h4);
    wb_read(ra(0, 8), 32'h0, "t1_done_cleared");

    // Source address wraps through zero
    mark();
    wb_write(ra(1, 0), 32'hFFFF_FFF8);
    wb_write(ra(1, 4), 32'd4);
    wb_write(ra(1, 8), 32'h1);
    wait_words(4);
    exp_seg(0, 32'hFFFF_FFF8, 4, 1, 1'b1);
    wb_read(ra(1, 0), 32'h8, "wrap_src");
    wb_read(ra(1, 8), 32'h4, "wrap_done");

    // Two channels interleaved round-robin
    do_reset();
    acc_ready_i = 1'b1;
    mark();
    wb_write(ra(0, 0), 32'h200);
    wb_write(ra(0, 4), 32'd6);
    wb_write(ra(1, 0), 32'h400);
    wb_write(ra(1, 4), 32'd4);
    wb_write(ra(0, 8), 32'h1);
    wb_write(ra(1, 8), 32'h1);
    wait_words(10);
    chk("rr_bursts", 64'(bursts.size() - bbase), 64'd3);
    chk("rr_b0", 64'(bursts[bbase]), 64'h200);
    chk("rr_b1", 64'(bursts[bbase + 1]), 64'h400);
    chk("rr_b2", 64'(bursts[bbase + 2]), 64'h210);
    exp_seg(0, 32'h200, 4, 0, 1'b0);
    exp_seg(4, 32'h400, 4, 1, 1'b1);
    exp_seg(8, 32'h210, 2, 0, 1'b1);
    wb_read(ra(0, 8), 32'h4, "rr_ctrl0");
    wb_read(ra(1, 8), 32'h4, "rr_ctrl1");

    // Back-pressure: full FIFO holds off the next burst
    do_reset();
    acc_ready_i = 1'b0;
    mark();
    wb_write(ra(0, 0), 32'h800);
    wb_write(ra(0, 4), 32'd12);
    wb_write(ra(0, 8), 32'h1);
    repeat (30) @(posedge wb_clk_i);
    #1;
    chk("bp_bursts1", 64'(bursts.size() - bbase), 64'd1);
    chk("bp_acks1", 64'(acks_total - abase), 64'd4);
    chk("bp_valid", 64'(acc_valid_o), 64'd1);
    chk("bp_cyc_idle", 64'(dram_cyc_o), 64'd0);
    acc_ready_i = 1'b1;
    repeat (3) @(posedge wb_clk_i);
    #1 acc_ready_i = 1'b0;
    repeat (20) @(posedge wb_clk_i);
    #1;
    chk("bp_popped3", 64'(words.size() - wbase), 64'd3);
    chk("bp_bursts_held", 64'(bursts.size() - bbase), 64'd1);
    acc_ready_i = 1'b1;
    wait_words(12);
    chk("bp_bursts3", 64'(bursts.size() - bbase), 64'd3);
    chk("bp_b1", 64'(bursts[bbase + 1]), 64'h810);
    chk("bp_b2", 64'(bursts[bbase + 2]), 64'h820);
    exp_seg(0, 32'h800, 12, 0, 1'b1);

    // Zero-length start with interrupt enabled
    do_reset();
    mark();
    wb_write(ra(0, 8), 32'h9);
    chk("zl_irq_high", 64'(irq_o), 64'd1);
    wb_read(ra(0, 8), 32'hC, "zl_ctrl");
    chk("zl_no_bursts", 64'(bursts.size() - bbase), 64'd0);
    wb_write(ra(0, 8), 32'hC);
    @(negedge wb_clk_i);
    chk("zl_irq_low", 64'(irq_o), 64'd0);
    @(posedge wb_clk_i); #1;
    wb_read(ra(0, 8), 32'h8, "zl_ctrl_cleared");

    // Writes to a busy channel are ignored
    do_reset();
    acc_ready_i = 1'b0;
    wb_write(ra(0, 0), 32'h1000);
    wb_write(ra(0, 4), 32'd12);
    wb_write(ra(0, 8), 32'h1);
    repeat (20) @(posedge wb_clk_i);
    #1;
    wb_write(ra(0, 0), 32'hDEAD_0000);
    wb_read(ra(0, 0), 32'h1010, "busy_src_kept");
    wb_write(ra(0, 4), 32'd3);
    wb_read(ra(0, 4), 32'd8, "busy_len_kept");
    wb_read(ra(0, 8), 32'h2, "busy_ctrl");

    // Reset during the second beat of a burst
    do_reset();
    acc_ready_i = 1'b1;
    wb_write(ra(0, 0), 32'h300);
    wb_write(ra(0, 4), 32'd4);
    wb_write(ra(0, 8), 32'h1);
    for (int i = 0; i < 50 && !dram_cyc_o; i++) begin
      @(posedge wb_clk_i); #1;
    end
    chk("mr_cyc_seen", 64'(dram_cyc_o), 64'd1);
    @(posedge wb_clk_i); #1;
    wb_rst_i = 1'b1;
    @(posedge wb_clk_i); #1;
    chk("mr_cyc_low", 64'(dram_cyc_o), 64'd0);
    chk("mr_stb_low", 64'(dram_stb_o), 64'd0);
    chk("mr_valid_low", 64'(acc_valid_o), 64'd0);
    wb_rst_i = 1'b0;
    wb_read(ra(0, 0), 32'h0, "mr_src");
    wb_read(ra(0, 4), 32'h0, "mr_len");
    wb_read(ra(0, 8), 32'h0, "mr_ctrl");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
